// File: rtl/command_parser_top.sv
// UART-attached register-access block: 8N1 receiver, transmitter and a frame parser
// servicing 6-byte write/read commands against an internal 32-bit register file.
module command_parser_top #(
  parameter int DIVISOR      = 434,
  parameter int SAMPLE_PHASE = DIVISOR / 2,
  parameter int NUM_REGS     = 32
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_tx
);

  localparam int CW = $clog2(DIVISOR);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_PHASE);
  localparam logic [7:0]    CMD_WRITE = 8'hAA;
  localparam logic [7:0]    CMD_READ  = 8'h00;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND} state_t;

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic            rx_valid, rx_valid_n;
  logic [7:0]      rx_byte;

  logic [8:0]      tx_shift;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic            tx_busy;
  logic            tx_ready;
  logic            tx_load;
  logic [7:0]      tx_data;

  state_t          state, state_n;
  logic            is_write;
  logic [7:0]      addr;
  logic [31:0]     data_buf;
  logic [1:0]      byte_cnt;
  logic [31:0]     tx_word;
  logic [31:0]     regs [NUM_REGS];
  logic            in_range;
  logic [AW-1:0]   idx;

  assign rx_byte  = rx_shift;
  assign in_range = (32'(addr) < 32'(NUM_REGS));
  assign idx      = addr[AW-1:0];
  assign tx_data  = tx_word[7:0];
  // Ready one clock early, on the last stop-bit clock, so bytes go out back-to-back.
  assign tx_ready = !tx_busy || ((tx_cnt == BIT_LAST) && (tx_bit == 4'd9));

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= i_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_valid <= rx_valid_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
        else                     rx_state_n = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt == SAMPLE_AT) begin
          rx_cnt_n = '0;
          rx_bit_n = 3'd0;
          // A start bit that reads high at its sample point was only a glitch.
          if (rx_sync) rx_state_n = RX_IDLE;
          else         rx_state_n = RX_DATA;
        end else begin
          rx_state_n = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_state_n = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_n = RX_IDLE;
          rx_valid_n = rx_sync;
        end else begin
          rx_state_n = RX_STOP;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_tx     <= 1'b1;
      tx_shift <= 9'h1FF;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_busy  <= 1'b0;
    end else if (tx_load) begin
      o_tx     <= 1'b0;
      tx_shift <= {1'b1, tx_data};
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          o_tx    <= 1'b1;
        end else begin
          o_tx     <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end else begin
      o_tx <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && ((rx_byte == CMD_WRITE) || (rx_byte == CMD_READ))) state_n = GET_ADDR;
        else                                                               state_n = IDLE;
      end
      GET_ADDR: begin
        if (rx_valid) state_n = GET_DATA;
        else          state_n = GET_ADDR;
      end
      GET_DATA: begin
        if (rx_valid && (byte_cnt == 2'd3)) state_n = EXEC;
        else                                state_n = GET_DATA;
      end
      EXEC: begin
        if (is_write) state_n = IDLE;
        else          state_n = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_load = 1'b1;
          if (byte_cnt == 2'd3) state_n = IDLE;
          else                  state_n = SEND;
        end else begin
          state_n = SEND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      is_write <= 1'b0;
      addr     <= 8'd0;
      data_buf <= 32'd0;
      byte_cnt <= 2'd0;
      tx_word  <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) is_write <= (rx_byte == CMD_WRITE);
        end
        GET_ADDR: begin
          if (rx_valid) begin
            addr     <= rx_byte;
            byte_cnt <= 2'd0;
          end
        end
        GET_DATA: begin
          // Shift in from the top so D0 ends up as the least significant byte.
          if (rx_valid) begin
            data_buf <= {rx_byte, data_buf[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        EXEC: begin
          byte_cnt <= 2'd0;
          if (in_range) begin
            if (is_write) regs[idx] <= data_buf;
            tx_word <= regs[idx];
          end else begin
            tx_word <= 32'd0;
          end
        end
        SEND: begin
          if (tx_load) begin
            tx_word  <= {8'h00, tx_word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_command_parser_top.sv
// Self-checking bench for command_parser_top: drives UART frames on i_rx and decodes o_tx
// against a queue of expected response bytes.
module tb_command_parser_top;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic i_reset;
  logic i_rx;
  logic o_tx;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic       mon_busy = 1'b0;

  command_parser_top #(
    .DIVISOR(DIV),
    .SAMPLE_PHASE(DIV / 2),
    .NUM_REGS(32)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_rx(i_rx),
    .o_tx(o_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    i_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
    send_byte(c, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d[7:0], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[31:24], 1'b1);
  endtask

  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 80 * DIV) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic quiet(input int bits, input string tag);
    int lows = 0;
    repeat (bits * DIV) begin
      @(negedge clk);
      if (o_tx !== 1'b1) lows++;
    end
    check(tag, 32'(lows), 32'd0);
  endtask

  task automatic read_reg(input logic [7:0] a, input logic [31:0] pay, input logic [31:0] want,
                          input string tag);
    expect_word(want);
    send_frame(8'h00, a, pay);
    drain(tag);
  endtask

  // Serial decoder for o_tx; every decoded byte is matched against the scoreboard.
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (i_reset === 1'b0 && o_tx === 1'b0) begin
        mon_busy = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        check("tx_start_bit", 32'(o_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          got[i] = o_tx;
        end
        repeat (DIV) @(negedge clk);
        check("tx_stop_bit", 32'(o_tx), 32'd1);
        check("tx_byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("tx_byte", 32'(got), 32'(exp_q.pop_front()));
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    i_reset = 1'b1;
    i_rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_high_a", 32'(o_tx), 32'd1);
    repeat (3) @(negedge clk);
    check("reset_tx_high_b", 32'(o_tx), 32'd1);
    i_reset = 1'b0;
    quiet(20, "idle_after_reset");
    read_reg(8'h12, 32'h0, 32'h0, "read_after_reset");

    send_frame(8'hAA, 8'h12, 32'h12345678);
    quiet(80, "write_no_response");
    read_reg(8'h12, 32'h78563412, 32'h12345678, "read_12");
    read_reg(8'h12, 32'h0, 32'h12345678, "read_12_again");

    send_byte(8'h55, 1'b1);
    send_frame(8'hAA, 8'h05, 32'hDEADBEEF);
    quiet(10, "unknown_cmd_quiet");
    read_reg(8'h05, 32'h0, 32'hDEADBEEF, "read_05");

    send_frame(8'hAA, 8'h40, 32'h44332211);
    quiet(10, "oob_write_quiet");
    read_reg(8'h40, 32'h0, 32'h0, "read_oob_40");
    read_reg(8'h00, 32'h0, 32'h0, "read_00_untouched");
    read_reg(8'h12, 32'h0, 32'h12345678, "read_12_after_oob");

    // Back-to-back write then read of the top register, no idle gap.
    send_frame(8'hAA, 8'h1F, 32'h04030201);
    expect_word(32'h04030201);
    send_frame(8'h00, 8'h1F, 32'h0);
    drain("read_1f_back_to_back");
    read_reg(8'h20, 32'h0, 32'h0, "read_oob_20");

    send_byte(8'h00, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    read_reg(8'h05, 32'h0, 32'hDEADBEEF, "read_after_framing_err");

    // A one-clock glitch inside a read frame must not be taken as the ADDR byte.
    expect_word(32'hDEADBEEF);
    send_byte(8'h00, 1'b1);
    i_rx = 1'b0;
    @(negedge clk);
    i_rx = 1'b1;
    quiet(12, "glitch_quiet");
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    drain("read_05_across_glitch");

    send_byte(8'hAA, 1'b1);
    send_byte(8'h07, 1'b1);
    i_reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_tx", 32'(o_tx), 32'd1);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    quiet(10, "abandoned_frame_quiet");
    read_reg(8'h07, 32'h0, 32'h0, "read_07_after_reset");
    read_reg(8'h12, 32'h0, 32'h0, "read_12_cleared");
    read_reg(8'h1F, 32'h0, 32'h0, "read_1f_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
